// File: rtl/sdft_sequencer.sv
// rtl/sdft_sequencer.sv - sample-period sequencer and frequency-bin RAM arbiter for the sliding DFT
module sdft_sequencer #(
  parameter int data_width    = 16,
  parameter int freq_bins     = 16,
  parameter int addr_width    = $clog2(freq_bins),
  parameter int sample_period = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [data_width-1:0] adc,
  output logic [data_width-1:0] sample,
  output logic                  sdft_start,
  input  logic                  sdft_done,
  input  logic                  bin_we,
  input  logic [addr_width-1:0] bin_addr,
  input  logic [data_width-1:0] bin_data,
  output logic                  bram_w_en,
  output logic [addr_width-1:0] bram_w_addr,
  output logic [data_width-1:0] bram_w_data,
  output logic                  bram_r_en,
  output logic [addr_width-1:0] bram_r_addr,
  input  logic [data_width-1:0] bram_r_data,
  input  logic                  rd_req,
  input  logic [addr_width-1:0] rd_addr,
  output logic                  rd_grant,
  output logic                  rd_valid,
  output logic [data_width-1:0] rd_data,
  input  logic                  rd_lock,
  output logic [15:0]           frame_count,
  output logic [15:0]           dropped,
  output logic                  busy
);

  localparam int tcnt_width = (sample_period > 1) ? $clog2(sample_period) : 1;
  localparam logic [tcnt_width-1:0] tcnt_last = tcnt_width'(sample_period - 1);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_START   = 2'd1,
    S_PROCESS = 2'd2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [tcnt_width-1:0]   tcnt;
  logic                    tick;
  logic                    load_sample;
  logic                    count_drop;
  logic                    count_frame;
  logic [data_width-1:0]   rd_data_q;

  assign tick = (tcnt == tcnt_last);

  // Free-running sample-period divider; independent of the FSM so ticks keep their phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle event decode; a tick that cannot start an update is a drop.
  always_comb begin
    next_state  = state;
    load_sample = 1'b0;
    count_drop  = 1'b0;
    count_frame = 1'b0;
    case (state)
      S_WAIT: begin
        if (tick) begin
          if (!rd_lock) begin
            load_sample = 1'b1;
            next_state  = S_START;
          end else begin
            count_drop = 1'b1;
          end
        end
      end
      S_START: begin
        count_drop = tick;
        next_state = S_PROCESS;
      end
      S_PROCESS: begin
        count_drop = tick;
        if (sdft_done) begin
          count_frame = 1'b1;
          next_state  = S_WAIT;
        end
      end
      default: begin
        next_state = S_WAIT;
      end
    endcase
  end

  // Sample latch: only written on an accepted tick, so it is frozen for the whole update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample <= '0;
    end else if (load_sample) begin
      sample <= adc;
    end
  end

  // Completed-update counter (wraps) and dropped-tick counter (saturates).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
      dropped     <= '0;
    end else begin
      if (count_frame) begin
        frame_count <= frame_count + 16'd1;
      end
      if (count_drop && (dropped != 16'hFFFF)) begin
        dropped <= dropped + 16'd1;
      end
    end
  end

  // Status and write-port pass-through; the sDFT owns the write port unconditionally.
  always_comb begin
    sdft_start  = (state == S_START);
    busy        = (state == S_START) || (state == S_PROCESS);
    bram_w_en   = bin_we;
    bram_w_addr = bin_addr;
    bram_w_data = bin_data;
  end

  // Read grant only while idle and off the tick, so a read never straddles a frame start.
  always_comb begin
    rd_grant    = rd_req && (state == S_WAIT) && !tick;
    bram_r_en   = rd_grant;
    bram_r_addr = rd_grant ? rd_addr : '0;
    rd_data     = rd_valid ? bram_r_data : rd_data_q;
  end

  // Read return: valid one cycle after grant, matching the RAM's read latency; data held between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_valid <= rd_grant;
      if (rd_valid) begin
        rd_data_q <= bram_r_data;
      end
    end
  end

endmodule

// File: tb/tb_sdft_sequencer.sv
// tb/tb_sdft_sequencer.sv - scoreboard bench for sdft_sequencer
module tb_sdft_sequencer;

  localparam int dw = 16;
  localparam int aw = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [dw-1:0] adc = '0;
  logic [dw-1:0] sample;
  logic          sdft_start;
  logic          sdft_done = 1'b0;
  logic          bin_we = 1'b0;
  logic [aw-1:0] bin_addr = '0;
  logic [dw-1:0] bin_data = '0;
  logic          bram_w_en;
  logic [aw-1:0] bram_w_addr;
  logic [dw-1:0] bram_w_data;
  logic          bram_r_en;
  logic [aw-1:0] bram_r_addr;
  logic [dw-1:0] bram_r_data;
  logic          rd_req = 1'b0;
  logic [aw-1:0] rd_addr = '0;
  logic          rd_grant;
  logic          rd_valid;
  logic [dw-1:0] rd_data;
  logic          rd_lock = 1'b0;
  logic [15:0]   frame_count;
  logic [15:0]   dropped;
  logic          busy;

  sdft_sequencer #(
    .data_width(dw), .freq_bins(16), .addr_width(aw), .sample_period(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .adc(adc), .sample(sample),
    .sdft_start(sdft_start), .sdft_done(sdft_done),
    .bin_we(bin_we), .bin_addr(bin_addr), .bin_data(bin_data),
    .bram_w_en(bram_w_en), .bram_w_addr(bram_w_addr), .bram_w_data(bram_w_data),
    .bram_r_en(bram_r_en), .bram_r_addr(bram_r_addr), .bram_r_data(bram_r_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_lock(rd_lock),
    .frame_count(frame_count), .dropped(dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;
  int n_starts = 0;
  int n_done = 0;
  int cyc = 0;
  int done_delay = 3;
  bit responder_en = 1'b1;
  bit check_period = 1'b0;
  bit have_prev = 1'b0;
  int prev_cyc = 0;
  int adc_val = 100;
  logic [dw-1:0] sample_q[$];
  logic [dw-1:0] rd_q[$];

  // single-port-per-direction RAM with 1-cycle read latency
  logic [dw-1:0] mem[16];
  always @(posedge clk) begin
    if (bram_w_en) mem[bram_w_addr] <= bram_w_data;
    if (bram_r_en) bram_r_data <= mem[bram_r_addr];
  end

  // reference tick phase for period 8
  logic [2:0] ref_tcnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ref_tcnt <= '0;
    else ref_tcnt <= ref_tcnt + 3'd1;
  end
  wire ref_tick = (ref_tcnt == 3'd7);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_for(input string tag, input bit on_done, input int target, input int budget);
    int cnt;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      cnt = on_done ? n_done : n_starts;
      if (cnt >= target) break;
    end
    cnt = on_done ? n_done : n_starts;
    check_eq(tag, 32'(cnt >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_sample"}, 32'(sample), 0);
    check_eq({tag, "_start"}, 32'(sdft_start), 0);
    check_eq({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check_eq({tag, "_rd_data"}, 32'(rd_data), 0);
    check_eq({tag, "_frame_count"}, 32'(frame_count), 0);
    check_eq({tag, "_dropped"}, 32'(dropped), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // sDFT responder: checks the latched sample at each start, moves adc, answers with done
  initial forever begin
    logic [dw-1:0] held;
    @(negedge clk);
    if (reset_n && sdft_start) begin
      n_starts++;
      check_eq("start_busy", 32'(busy), 1);
      check_eq("sample_q_depth", 32'(sample_q.size() != 0), 1);
      if (sample_q.size() != 0) check_eq("sample", 32'(sample), 32'(sample_q.pop_front()));
      if (check_period && have_prev) check_eq("start_period", 32'(cyc - prev_cyc), 8);
      prev_cyc = cyc;
      have_prev = 1'b1;
      held = sample;
      adc_val += 100;
      adc = 16'(adc_val);
      sample_q.push_back(16'(adc_val));
      if (responder_en) begin
        repeat (done_delay) @(posedge clk);
        #1 sdft_done = 1'b1;
        @(negedge clk);
        check_eq("sample_hold", 32'(sample), 32'(held));
        @(posedge clk);
        #1 sdft_done = 1'b0;
        n_done++;
        check_eq("busy_after_done", 32'(busy), 0);
      end
    end
  end

  // read-port monitor: grant rules, read latency and returned data
  initial begin
    bit prev_grant = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_grant = 1'b0;
        rd_q.delete();
      end else begin
        if (rd_valid || prev_grant) check_eq("rd_valid_latency", 32'(rd_valid), 32'(prev_grant));
        if (rd_valid) begin
          check_eq("rd_q_depth", 32'(rd_q.size() != 0), 1);
          if (rd_q.size() != 0) check_eq("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        end
        if (rd_req && (ref_tick || busy)) check_eq("rd_grant_blocked", 32'(rd_grant), 0);
        if (rd_grant) begin
          check_eq("bram_r_en", 32'(bram_r_en), 1);
          check_eq("bram_r_addr", 32'(bram_r_addr), 32'(rd_addr));
          rd_q.push_back(16'(rd_addr * 3));
        end
        prev_grant = rd_grant;
      end
    end
  end

  initial begin
    int d0, f0, s0, base;
    bit got;

    // reset state
    adc = 16'd100;
    sample_q.push_back(16'd100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // three updates, done 3 cycles after start
    check_period = 1'b1;
    wait_for("t1_three_done", 1'b1, 3, 100);
    check_eq("t1_frame_count", 32'(frame_count), 3);
    check_eq("t1_dropped", 32'(dropped), 0);
    check_period = 1'b0;

    // long updates: one tick dropped per update
    done_delay = 12;
    d0 = int'(dropped);
    f0 = int'(frame_count);
    base = n_done;
    wait_for("t2_four_done", 1'b1, base + 4, 200);
    check_eq("t2_dropped", 32'(int'(dropped) - d0), 4);
    check_eq("t2_frame_count", 32'(int'(frame_count) - f0), 4);

    // reader lock for 40 cycles
    rd_lock = 1'b1;
    done_delay = 3;
    s0 = n_starts;
    d0 = int'(dropped);
    f0 = int'(frame_count);
    repeat (40) @(posedge clk);
    #1 rd_lock = 1'b0;
    check_eq("t3_no_start", 32'(n_starts), 32'(s0));
    check_eq("t3_dropped", 32'(int'(dropped) - d0), 5);
    check_eq("t3_frame_count", 32'(frame_count), 32'(f0));

    // bin write-back during S_PROCESS passes straight through
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (busy && !sdft_start) got = 1'b1;
    end
    check_eq("t4_reach_process", 32'(got), 1);
    #1;
    bin_we = 1'b1;
    bin_addr = 4'd5;
    bin_data = 16'h1234;
    #1;
    check_eq("t4_w_en", 32'(bram_w_en), 1);
    check_eq("t4_w_addr", 32'(bram_w_addr), 5);
    check_eq("t4_w_data", 32'(bram_w_data), 32'h1234);
    @(posedge clk);
    #1 bin_we = 1'b0;
    check_eq("t4_w_en_low", 32'(bram_w_en), 0);

    // preload RAM with addr*3 through the write path
    for (int a = 0; a < 16; a++) begin
      bin_we = 1'b1;
      bin_addr = 4'(a);
      bin_data = 16'(a * 3);
      @(negedge clk);
      check_eq("preload_w_data", 32'(bram_w_data), 32'(a * 3));
      @(posedge clk);
      #1;
    end
    bin_we = 1'b0;

    // reader sweeps all bins, holding each request until granted
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      rd_req = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (rd_grant) got = 1'b1;
      end
      check_eq("rd_grant_timeout", 32'(got), 1);
      @(posedge clk);
      #1;
    end
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rd_q_drained", 32'(rd_q.size()), 0);

    // reset in the middle of S_PROCESS, then a stray done
    responder_en = 1'b0;
    base = n_starts;
    wait_for("t6_start", 1'b0, base + 1, 60);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1 sdft_done = 1'b1;
    @(posedge clk);
    #1 sdft_done = 1'b0;
    @(negedge clk);
    check_eq("t6_frame_count", 32'(frame_count), 0);
    check_eq("t6_busy", 32'(busy), 0);
    check_eq("t6_start_low", 32'(sdft_start), 0);
    check_eq("t6_dropped", 32'(dropped), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
